// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared register-address bus, zero-register constant and data-memory handshake states.
package pipe_hazard_ctrl_pkg;
    localparam int REG_ADDR_BITS = 5;
    typedef logic [REG_ADDR_BITS-1:0] Reg_Addr_Bus;
    localparam Reg_Addr_Bus ZERO_REG = '0;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } memState_t;
endpackage

// File: rtl/pipe_hazard_ctrl_dmem_handshake_fsm.sv
// dmem_handshake_fsm: req/ready handshake for variable-latency data memory with timeout into a sticky error state.
module dmem_handshake_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic memAccess,
    input  logic dmemReady,
    output logic dmemReq,
    output logic memStall,
    output logic memError
);
    memState_t state;
    logic [7:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            tcnt  <= '0;
        end else begin
            case (state)
                RUN: if (memAccess && !dmemReady) begin
                    state <= MEM_WAIT;
                    tcnt  <= 8'd1;
                end
                MEM_WAIT: if (dmemReady) begin
                    state <= RUN;
                    tcnt  <= '0;
                end else if (tcnt == 8'(MEM_TIMEOUT - 1)) begin
                    state <= ERR;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
                default: state <= ERR;
            endcase
        end
    end

    // A zero-wait access completes in RUN without ever stalling.
    assign dmemReq  = (state == MEM_WAIT) || (state == RUN && memAccess);
    assign memStall = (state == ERR) || (state == MEM_WAIT && !dmemReady) ||
                      (state == RUN && memAccess && !dmemReady);
    assign memError = (state == ERR);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush sequencer for load-use hazards, taken branches and data-memory waits.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_BITS,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_Rs_num,
    input  logic [REG_ADDR_W-1:0] ID_Rt_num,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  ID_BranchTaken,
    input  logic [REG_ADDR_W-1:0] EX_Reg_WriteAddr,
    input  logic                  EX_Reg_WriteEn,
    input  logic                  EX_Mem2R,
    input  logic                  MEM_DMem_ReadEn,
    input  logic                  MEM_DMem_WriteEn,
    input  logic                  DMem_Ready,
    output logic                  DMem_Req,
    output logic                  PC_Stall,
    output logic                  IF_ID_Stall,
    output logic                  IF_ID_Flush,
    output logic                  ID_EX_Stall,
    output logic                  ID_EX_Flush,
    output logic                  EX_MEM_Stall,
    output logic                  MEM_WB_Flush,
    output logic                  Mem_Error,
    output logic [CNT_W-1:0]      Stall_Cnt
);
    logic memStall, loadUse;

    dmem_handshake_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) memFsm (
        .clk       (clk),
        .rst       (rst),
        .memAccess (MEM_DMem_ReadEn | MEM_DMem_WriteEn),
        .dmemReady (DMem_Ready),
        .dmemReq   (DMem_Req),
        .memStall  (memStall),
        .memError  (Mem_Error)
    );

    assign loadUse = EX_Mem2R && EX_Reg_WriteEn && (EX_Reg_WriteAddr != REG_ADDR_W'(ZERO_REG)) &&
                     ((ID_UsesRs && ID_Rs_num == EX_Reg_WriteAddr) ||
                      (ID_UsesRt && ID_Rt_num == EX_Reg_WriteAddr));

    // Branch flush yields to any stall: under load-use its operands are not yet valid.
    assign PC_Stall     = memStall || loadUse;
    assign IF_ID_Stall  = PC_Stall;
    assign IF_ID_Flush  = !PC_Stall && ID_BranchTaken;
    assign ID_EX_Stall  = memStall;
    assign ID_EX_Flush  = !memStall && loadUse;
    assign EX_MEM_Stall = memStall;
    assign MEM_WB_Flush = memStall;

    always_ff @(posedge clk) begin
        if (rst)
            Stall_Cnt <= '0;
        else if (PC_Stall && Stall_Cnt != '1)
            Stall_Cnt <= Stall_Cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a cycle-counting reference model.
module tb_pipe_hazard_ctrl;
    localparam int TMO = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] ID_Rs_num, ID_Rt_num, EX_Reg_WriteAddr;
    logic ID_UsesRs, ID_UsesRt, ID_BranchTaken, EX_Reg_WriteEn, EX_Mem2R;
    logic MEM_DMem_ReadEn, MEM_DMem_WriteEn, DMem_Ready;
    logic DMem_Req, PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush;
    logic EX_MEM_Stall, MEM_WB_Flush, Mem_Error;
    logic [CW-1:0] Stall_Cnt;

    int checks = 0;
    int passes = 0;
    int mWait = 0;
    bit mErr = 1'b0;
    int mCnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs_num(ID_Rs_num), .ID_Rt_num(ID_Rt_num),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_BranchTaken(ID_BranchTaken),
        .EX_Reg_WriteAddr(EX_Reg_WriteAddr), .EX_Reg_WriteEn(EX_Reg_WriteEn), .EX_Mem2R(EX_Mem2R),
        .MEM_DMem_ReadEn(MEM_DMem_ReadEn), .MEM_DMem_WriteEn(MEM_DMem_WriteEn),
        .DMem_Ready(DMem_Ready), .DMem_Req(DMem_Req),
        .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Stall(ID_EX_Stall), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Stall(EX_MEM_Stall),
        .MEM_WB_Flush(MEM_WB_Flush), .Mem_Error(Mem_Error), .Stall_Cnt(Stall_Cnt)
    );

    function automatic logic [12:0] observed();
        return {DMem_Req, PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
                EX_MEM_Stall, MEM_WB_Flush, Mem_Error, Stall_Cnt};
    endfunction

    // Memory is stalled while an access (new or already waiting) lacks Ready, or forever after a timeout.
    function automatic bit memStallM();
        return mErr || ((MEM_DMem_ReadEn || MEM_DMem_WriteEn || mWait > 0) && !DMem_Ready);
    endfunction

    function automatic bit loadUseM();
        return EX_Mem2R && EX_Reg_WriteEn && EX_Reg_WriteAddr != 0 &&
               ((ID_UsesRs && ID_Rs_num == EX_Reg_WriteAddr) || (ID_UsesRt && ID_Rt_num == EX_Reg_WriteAddr));
    endfunction

    function automatic logic [12:0] expected();
        bit ms, lu, req;
        ms = memStallM();
        lu = loadUseM();
        req = !mErr && (MEM_DMem_ReadEn || MEM_DMem_WriteEn || mWait > 0);
        return {req, ms || lu, ms || lu, !(ms || lu) && ID_BranchTaken, ms, !ms && lu,
                ms, ms, mErr, CW'(mCnt)};
    endfunction

    task automatic tick();
        bit ms, ps;
        ms = memStallM();
        ps = ms || loadUseM();
        if (rst) begin
            mWait = 0; mErr = 1'b0; mCnt = 0;
        end else begin
            if (ps && mCnt < 2**CW - 1) mCnt++;
            if (!mErr) begin
                if (ms) begin
                    mWait++;
                    mErr = (mWait == TMO);
                end else mWait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs_num = '0; ID_Rt_num = '0; ID_UsesRs = 0; ID_UsesRt = 0; ID_BranchTaken = 0;
        EX_Reg_WriteAddr = '0; EX_Reg_WriteEn = 0; EX_Mem2R = 0;
        MEM_DMem_ReadEn = 0; MEM_DMem_WriteEn = 0; DMem_Ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_load_use(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        EX_Mem2R = 1; EX_Reg_WriteEn = 1; EX_Reg_WriteAddr = dst;
        ID_Rs_num = rs; ID_Rt_num = rt; ID_UsesRs = 1; ID_UsesRt = 1;
    endtask

    task automatic test_reset();
        ID_BranchTaken = 1; MEM_DMem_ReadEn = 1; EX_Mem2R = 1;
        rst = 1;
        tick();
        tick();
        rst = 0;
        idle();
        #3;
        if (observed() !== 13'b0) $display("FAIL reset got=%b exp=%b", observed(), 13'b0);
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd8, 5'd8, 5'd3);
        #3;
        if (observed() !== expected() || {PC_Stall, IF_ID_Stall, ID_EX_Flush, ID_EX_Stall} !== 4'b1110)
            $display("FAIL load_use_rs got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        tick();
        idle(); EX_Reg_WriteEn = 1; EX_Reg_WriteAddr = 5'd9; ID_Rs_num = 5'd8; ID_UsesRs = 1;
        #3;
        if (observed() !== expected() || {PC_Stall, IF_ID_Stall, ID_EX_Flush} !== 3'b000 || Stall_Cnt !== 4'd1)
            $display("FAIL load_use_release got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        tick();
        set_load_use(5'd17, 5'd2, 5'd17);
        #3;
        if (observed() !== expected() || ID_EX_Flush !== 1'b1)
            $display("FAIL load_use_rt got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_load_use(5'd0, 5'd0, 5'd0);
        #3;
        if (observed() !== expected() || observed() !== 13'b0)
            $display("FAIL zero_reg got=%b exp=%b", observed(), 13'b0);
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        ID_BranchTaken = 1;
        #3;
        if (observed() !== expected() || {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush} !== 4'b0010)
            $display("FAIL branch got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        tick();
        idle();
        #3;
        if (IF_ID_Flush !== 1'b0)
            $display("FAIL branch_one_cycle got=%b exp=0", IF_ID_Flush);
        else passes++;
        checks++;
        tick();
        set_load_use(5'd4, 5'd4, 5'd1);
        ID_BranchTaken = 1;
        #3;
        if (observed() !== expected() || {PC_Stall, IF_ID_Flush, ID_EX_Flush} !== 3'b101)
            $display("FAIL branch_vs_load_use got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_mem_wait();
        int reqN, stN;
        do_reset();
        MEM_DMem_ReadEn = 1;
        reqN = 0; stN = 0;
        for (int c = 0; c < 4; c++) begin
            DMem_Ready = (c == 3);
            #3;
            if (observed() !== expected())
                $display("FAIL mem_wait_c%0d got=%b exp=%b", c, observed(), expected());
            else passes++;
            checks++;
            reqN += int'(DMem_Req);
            stN += int'(PC_Stall && IF_ID_Stall && ID_EX_Stall && EX_MEM_Stall && MEM_WB_Flush);
            tick();
        end
        idle();
        if (reqN != 4 || stN != 3 || Stall_Cnt !== 4'd3)
            $display("FAIL mem_wait_totals got req=%0d stall=%0d cnt=%0d exp req=4 stall=3 cnt=3", reqN, stN, Stall_Cnt);
        else passes++;
        checks++;
        MEM_DMem_WriteEn = 1; DMem_Ready = 1;
        #3;
        if (observed() !== expected() || {DMem_Req, PC_Stall, MEM_WB_Flush} !== 3'b100)
            $display("FAIL mem_zero_wait got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_timeout();
        int errAt;
        do_reset();
        MEM_DMem_ReadEn = 1;
        errAt = -1;
        for (int c = 0; c < 7; c++) begin
            #3;
            if (Mem_Error && errAt < 0) errAt = c;
            if (observed() !== expected())
                $display("FAIL timeout_c%0d got=%b exp=%b", c, observed(), expected());
            else passes++;
            checks++;
            tick();
        end
        if (errAt != 4 || {DMem_Req, Mem_Error, PC_Stall, EX_MEM_Stall, MEM_WB_Flush} !== 5'b01111)
            $display("FAIL timeout_err got errAt=%0d req=%b err=%b stall=%b exp errAt=4 req=0 err=1 stall=1",
                     errAt, DMem_Req, Mem_Error, PC_Stall);
        else passes++;
        checks++;
        do_reset();
        #3;
        if (observed() !== 13'b0)
            $display("FAIL timeout_reset got=%b exp=%b", observed(), 13'b0);
        else passes++;
        checks++;
        tick();
        MEM_DMem_ReadEn = 1; DMem_Ready = 1;
        #3;
        if (observed() !== expected() || {DMem_Req, PC_Stall} !== 2'b10)
            $display("FAIL timeout_run_after_reset got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use(5'd12, 5'd12, 5'd0);
        for (int c = 0; c < 20; c++) tick();
        idle();
        #3;
        if (Stall_Cnt !== 4'd15 || observed() !== expected())
            $display("FAIL saturation got=%0d exp=15", Stall_Cnt);
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        MEM_DMem_ReadEn = 1;
        tick();
        tick();
        #3;
        if (DMem_Req !== 1'b1 || observed() !== expected())
            $display("FAIL mid_wait_pre got=%b exp=%b", observed(), expected());
        else passes++;
        checks++;
        do_reset();
        #3;
        if ({DMem_Req, PC_Stall} !== 2'b00 || Stall_Cnt !== 4'd0 || observed() !== expected())
            $display("FAIL mid_wait_reset got=%b exp=%b", observed(), 13'b0);
        else passes++;
        checks++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            ID_Rs_num = 5'($urandom_range(0, 3));
            ID_Rt_num = 5'($urandom_range(0, 3));
            EX_Reg_WriteAddr = 5'($urandom_range(0, 3));
            ID_UsesRs = 1'($urandom_range(0, 1));
            ID_UsesRt = 1'($urandom_range(0, 1));
            ID_BranchTaken = 1'($urandom_range(0, 1));
            EX_Reg_WriteEn = 1'($urandom_range(0, 1));
            EX_Mem2R = 1'($urandom_range(0, 1));
            MEM_DMem_ReadEn = ($urandom_range(0, 3) == 0);
            MEM_DMem_WriteEn = ($urandom_range(0, 5) == 0);
            DMem_Ready = 1'($urandom_range(0, 1));
            #3;
            if (!rst) begin
                if (observed() !== expected())
                    $display("FAIL random_c%0d got=%b exp=%b", c, observed(), expected());
                else passes++;
                checks++;
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives hold/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and resolves taken-branch squashes.
- Runs a req/ready handshake FSM for variable-latency data memory, with timeout detection and a saturating stall counter.

Parameters:
- REG_ADDR_W, 5, register address width.
- MEM_TIMEOUT, 16, maximum cycles in MEM_WAIT before error; legal range 2..255.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset, sampled on posedge clk.
- ID_Rs_num  in  REG_ADDR_W  rs of the ID-stage instruction.
- ID_Rt_num  in  REG_ADDR_W  rt of the ID-stage instruction.
- ID_UsesRs  in  1  ID instruction reads rs.
- ID_UsesRt  in  1  ID instruction reads rt.
- ID_BranchTaken  in  1  branch/jump resolved taken in ID.
- EX_Reg_WriteAddr  in  REG_ADDR_W  destination of the EX instruction.
- EX_Reg_WriteEn  in  1  EX instruction writes a register.
- EX_Mem2R  in  1  EX instruction is a load.
- MEM_DMem_ReadEn  in  1  MEM instruction reads DMem.
- MEM_DMem_WriteEn  in  1  MEM instruction writes DMem.
- DMem_Ready  in  1  memory completes the current access this cycle.
- DMem_Req  out  1  access request to data memory.
- PC_Stall  out  1  hold PC.
- IF_ID_Stall  out  1  hold IF/ID.
- IF_ID_Flush  out  1  load NOP into IF/ID.
- ID_EX_Stall  out  1  hold ID/EX.
- ID_EX_Flush  out  1  load NOP into ID/EX.
- EX_MEM_Stall  out  1  hold EX/MEM.
- MEM_WB_Flush  out  1  load NOP into MEM/WB.
- Mem_Error  out  1  sticky timeout flag.
- Stall_Cnt  out  CNT_W  count of cycles with PC_Stall=1, saturating.

Behaviour:
- Reset: all control outputs 0; FSM enters RUN; timeout counter 0; Mem_Error 0; Stall_Cnt 0. Reset mid-wait abandons the access and DMem_Req drops the next cycle.
- Every control output is combinational from the inputs and the registered state. The controlled pipeline registers act on the same posedge.
- mem_access = MEM_DMem_ReadEn | MEM_DMem_WriteEn.
- FSM states:
  - RUN: DMem_Req = mem_access; mem_stall = mem_access & ~DMem_Ready. A zero-wait access (Ready in the same cycle) causes no stall. If mem_stall, go to MEM_WAIT with tcnt = 1.
  - MEM_WAIT: DMem_Req = 1; mem_stall = ~DMem_Ready.
    - On Ready, go to RUN. Stall drops in that same cycle, so the pipeline advances.
    - If Ready is absent and tcnt == MEM_TIMEOUT-1, go to ERR. Otherwise tcnt++.
  - ERR: DMem_Req = 0; mem_stall = 1 permanently; Mem_Error = 1. Leave only on rst.
- load_use = EX_Mem2R & EX_Reg_WriteEn & (EX_Reg_WriteAddr != 0) & ((ID_UsesRs & rs match) | (ID_UsesRt & rt match)).
- Priority, highest first:
  - mem_stall: PC, IF_ID, ID_EX and EX_MEM stall = 1; MEM_WB_Flush = 1; all other flushes 0.
  - load_use: PC_Stall = IF_ID_Stall = 1; ID_EX_Flush = 1. ID_BranchTaken is ignored, because its operands are not yet valid.
  - ID_BranchTaken: IF_ID_Flush = 1 only.
  - Otherwise all controls are 0.
- A stall and a flush are never asserted on the same register in the same cycle.
- Stall_Cnt increments on each posedge where PC_Stall = 1 and holds at 2^CNT_W - 1.

Decomposition:
- Shared include, alongside the existing bus definitions:
  - FSM state encoding: RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2.
  - Reg_Addr_Bus width.
  - Zero-register constant.
- Natural sub-module: dmem_handshake_fsm, containing the FSM, the timeout counter and Mem_Error.
- The top level holds hazard detection, priority muxing and Stall_Cnt.

Test Plan:
- Load-use: EX lw to $8 (Mem2R=1, WriteEn=1, addr 8); ID add reading rs=8 -> exactly 1 cycle of PC_Stall=IF_ID_Stall=ID_EX_Flush=1, then all 0; Stall_Cnt=1.
- Zero register: same as the load-use case but EX addr 0 -> no stall.
- Branch: ID_BranchTaken=1, no hazard -> IF_ID_Flush=1 for 1 cycle. With a load-use present in the same cycle -> only the load-use controls assert, IF_ID_Flush=0.
- Memory wait:
  - MEM_DMem_ReadEn=1 with Ready asserted 3 cycles late -> DMem_Req high 4 cycles; all stalls and MEM_WB_Flush high 3 cycles; Stall_Cnt=3.
  - Ready in the same cycle -> no stall.
- Timeout: MEM_TIMEOUT=4, ReadEn held, Ready never -> enter ERR on cycle 4. Then Mem_Error=1, DMem_Req=0, stalls held high. rst -> all outputs 0, state RUN.
- Saturation and reset mid-wait:
  - CNT_W=4, 20 stall cycles -> Stall_Cnt=15.
  - rst during MEM_WAIT -> next cycle DMem_Req=0, Stall_Cnt=0.
